// File: rtl/instr_decode_pipe.sv
// rtl/instr_decode_pipe.sv - instruction decoder with a one-cycle output register and skid buffer
module instr_decode_pipe #(
  parameter int XLEN    = 32,
  parameter int LOCK_EN = 1,
  parameter int SEXT    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic            out_lock_req,
  output logic            out_lock_rel,
  output logic [15:0]     dec_count
);

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [2:0]      fmt;
    logic            illegal;
    logic            lock_req;
    logic            lock_rel;
  } dec_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_SH = 3'd2, FMT_S = 3'd3;
  localparam logic [2:0] FMT_B = 3'd4, FMT_U = 3'd5, FMT_J = 3'd6, FMT_LOCK = 3'd7;
  localparam logic       LOCK_ON = (LOCK_EN != 0);
  localparam logic       SEXT_ON = (SEXT != 0);

  state_t          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  dec_t            out_q, out_d, skid_q, skid_d, dec, out_view;
  logic [15:0]     cnt_q, cnt_d;
  logic            in_fire, out_fire;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  // Immediate candidates; the SEXT choice is a fixed per-instance build option
  always_comb begin
    imm_i = SEXT_ON ? XLEN'($signed(in_instr[31:20])) : XLEN'(in_instr[31:20]);
    imm_s = SEXT_ON ? XLEN'($signed({in_instr[31:25], in_instr[11:7]}))
                    : XLEN'({in_instr[31:25], in_instr[11:7]});
    imm_b = SEXT_ON ? XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}))
                    : XLEN'({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0});
    imm_u = SEXT_ON ? XLEN'($signed({in_instr[31:12], 12'b0})) : XLEN'({in_instr[31:12], 12'b0});
    imm_j = SEXT_ON ? XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}))
                    : XLEN'({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0});
  end

  // Decode the incoming word; fields a format does not use stay zero
  always_comb begin
    dec        = '0;
    dec.opcode = in_instr[6:0];
    dec.pc     = in_pc;
    case (in_instr[6:0])
      7'h33: begin
        dec.fmt = FMT_R;  dec.funct7 = in_instr[31:25]; dec.rs2 = in_instr[24:20];
        dec.rs1 = in_instr[19:15]; dec.funct3 = in_instr[14:12]; dec.rd = in_instr[11:7];
      end
      7'h13: begin
        dec.rs1 = in_instr[19:15]; dec.funct3 = in_instr[14:12]; dec.rd = in_instr[11:7];
        if (in_instr[13:12] == 2'b01) begin
          // Shift-immediate: only funct7 0x00, or 0x20 for the arithmetic right shift, is valid
          dec.fmt     = FMT_SH;
          dec.funct7  = in_instr[31:25];
          dec.imm     = XLEN'(in_instr[24:20]);
          dec.illegal = !((in_instr[31:25] == 7'h00) ||
                          (in_instr[31:25] == 7'h20 && in_instr[14:12] == 3'b101));
        end else begin
          dec.fmt = FMT_I; dec.imm = imm_i;
        end
      end
      7'h67, 7'h03, 7'h7E: begin
        if (in_instr[6:0] != 7'h7E || LOCK_ON) begin
          dec.fmt = FMT_I; dec.rs1 = in_instr[19:15]; dec.funct3 = in_instr[14:12];
          dec.rd  = in_instr[11:7]; dec.imm = imm_i;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      7'h23, 7'h7F: begin
        if (in_instr[6:0] != 7'h7F || LOCK_ON) begin
          dec.fmt = FMT_S; dec.rs2 = in_instr[24:20]; dec.rs1 = in_instr[19:15];
          dec.funct3 = in_instr[14:12]; dec.imm = imm_s;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      7'h63: begin
        dec.fmt = FMT_B; dec.rs2 = in_instr[24:20]; dec.rs1 = in_instr[19:15];
        dec.funct3 = in_instr[14:12]; dec.imm = imm_b;
      end
      7'h37, 7'h17: begin
        dec.fmt = FMT_U; dec.rd = in_instr[11:7]; dec.imm = imm_u;
      end
      7'h6F: begin
        dec.fmt = FMT_J; dec.rd = in_instr[11:7]; dec.imm = imm_j;
      end
      7'h40, 7'h20: begin
        if (LOCK_ON) begin
          dec.fmt      = FMT_LOCK;
          dec.imm      = XLEN'(in_instr[31:12]);
          dec.lock_req = (in_instr[6:0] == 7'h40);
          dec.lock_rel = (in_instr[6:0] == 7'h20);
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Handshake outputs: in_ready comes from a flop, gated only by reset
  always_comb begin
    in_ready   = in_ready_q && !rst;
    out_valid  = (state_q != EMPTY) && !rst;
    in_fire    = in_valid && in_ready;
    out_fire   = out_valid && out_ready;
    in_ready_d = (state_d != FULL);
  end

  // Next-state logic; flush wins over any input arriving on the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (in_fire) state_d = ONE;
      ONE: begin
        if (in_fire && !out_fire)      state_d = FULL;
        else if (!in_fire && out_fire) state_d = EMPTY;
      end
      FULL:    if (out_fire) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  // Entry movement between decoder, output register and skid register
  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    cnt_d  = cnt_q + {15'd0, out_fire};
    case (state_q)
      EMPTY: if (in_fire) out_d = dec;
      ONE: begin
        if (in_fire && out_fire) out_d  = dec;
        else if (in_fire)        skid_d = dec;
      end
      FULL:    if (out_fire) out_d = skid_q;
      default: ;
    endcase
  end

  // State register; in_ready_q resets high so the port rises as soon as rst drops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Datapath and transfer counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      out_q  <= out_d;
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
    end
  end

  // Output fields read as zero while reset is held
  always_comb begin
    out_view     = rst ? '0 : out_q;
    out_opcode   = out_view.opcode;
    out_funct3   = out_view.funct3;
    out_funct7   = out_view.funct7;
    out_rs1      = out_view.rs1;
    out_rs2      = out_view.rs2;
    out_rd       = out_view.rd;
    out_imm      = out_view.imm;
    out_pc       = out_view.pc;
    out_fmt      = out_view.fmt;
    out_illegal  = out_view.illegal;
    out_lock_req = out_view.lock_req;
    out_lock_rel = out_view.lock_rel;
    dec_count    = rst ? 16'd0 : cnt_q;
  end

endmodule

// File: tb/tb_instr_decode_pipe.sv
// tb/tb_instr_decode_pipe.sv - directed table-driven bench for instr_decode_pipe
module tb_instr_decode_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [63:0] in_pc64;

  logic        o_rdy, o_vld, o_ill, o_lreq, o_lrel;
  logic [6:0]  o_op, o_f7;
  logic [2:0]  o_f3, o_fmt;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [31:0] o_imm, o_pc;
  logic [15:0] o_cnt;

  logic        n_rdy, n_vld, n_ill, n_lreq, n_lrel;
  logic [6:0]  n_op, n_f7;
  logic [2:0]  n_f3, n_fmt;
  logic [4:0]  n_rs1, n_rs2, n_rd;
  logic [31:0] n_imm, n_pc;
  logic [15:0] n_cnt;

  logic        w_rdy, w_vld, w_ill, w_lreq, w_lrel;
  logic [6:0]  w_op, w_f7;
  logic [2:0]  w_f3, w_fmt;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [63:0] w_imm, w_pc;
  logic [15:0] w_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  instr_decode_pipe #(.XLEN(32), .LOCK_EN(1), .SEXT(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o_rdy),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(o_vld), .out_ready(out_ready),
    .out_opcode(o_op), .out_funct3(o_f3), .out_funct7(o_f7), .out_rs1(o_rs1),
    .out_rs2(o_rs2), .out_rd(o_rd), .out_imm(o_imm), .out_pc(o_pc), .out_fmt(o_fmt),
    .out_illegal(o_ill), .out_lock_req(o_lreq), .out_lock_rel(o_lrel), .dec_count(o_cnt));

  instr_decode_pipe #(.XLEN(32), .LOCK_EN(0), .SEXT(0)) dut_nl (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_rdy),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(n_vld), .out_ready(out_ready),
    .out_opcode(n_op), .out_funct3(n_f3), .out_funct7(n_f7), .out_rs1(n_rs1),
    .out_rs2(n_rs2), .out_rd(n_rd), .out_imm(n_imm), .out_pc(n_pc), .out_fmt(n_fmt),
    .out_illegal(n_ill), .out_lock_req(n_lreq), .out_lock_rel(n_lrel), .dec_count(n_cnt));

  instr_decode_pipe #(.XLEN(64), .LOCK_EN(1), .SEXT(1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(w_rdy),
    .in_instr(in_instr), .in_pc(in_pc64), .out_valid(w_vld), .out_ready(out_ready),
    .out_opcode(w_op), .out_funct3(w_f3), .out_funct7(w_f7), .out_rs1(w_rs1),
    .out_rs2(w_rs2), .out_rd(w_rd), .out_imm(w_imm), .out_pc(w_pc), .out_fmt(w_fmt),
    .out_illegal(w_ill), .out_lock_req(w_lreq), .out_lock_rel(w_lrel), .dec_count(w_cnt));

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill, lreq, lrel, ill_nl;
    logic [31:0] imm_z;
    logic [63:0] imm64;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    //           instr          fmt   rd    rs1   rs2   f3    f7      imm32          ill   lreq  lrel  ill_nl imm_z          imm64
    vecs[0]  = '{32'hFFF00093, 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000FFF, 64'hFFFFFFFFFFFFFFFF};
    vecs[1]  = '{32'h402081B3, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 64'h0};
    vecs[2]  = '{32'h40105093, 3'd2, 5'd1, 5'd0, 5'd0, 3'd5, 7'h20, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000001, 64'h1};
    vecs[3]  = '{32'h40101093, 3'd2, 5'd1, 5'd0, 5'd0, 3'd1, 7'h20, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000001, 64'h1};
    vecs[4]  = '{32'hFE20AE23, 3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000FFC, 64'hFFFFFFFFFFFFFFFC};
    vecs[5]  = '{32'hFE208CE3, 3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFF8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00001FF8, 64'hFFFFFFFFFFFFFFF8};
    vecs[6]  = '{32'h123452B7, 3'd5, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345000, 64'h0000000012345000};
    vecs[7]  = '{32'hFFFFF297, 3'd5, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF000, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000};
    vecs[8]  = '{32'hFFDFF0EF, 3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 1'b0, 32'h001FFFFC, 64'hFFFFFFFFFFFFFFFC};
    vecs[9]  = '{32'h0080006F, 3'd6, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000008, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000008, 64'h8};
    vecs[10] = '{32'h00001040, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000000, 64'h1};
    vecs[11] = '{32'hABCDE020, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h000ABCDE, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000000, 64'hABCDE};
    vecs[12] = '{32'h8000A0FE, 3'd1, 5'd1, 5'd1, 5'd0, 3'd2, 7'h00, 32'hFFFFF800, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000000, 64'hFFFFFFFFFFFFF800};
    vecs[13] = '{32'h0020807F, 3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000000, 64'h0};
    vecs[14] = '{32'h0000000B, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000000, 64'h0};
    vecs[15] = '{32'h00311093, 3'd2, 5'd1, 5'd2, 5'd0, 3'd1, 7'h00, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000003, 64'h3};
    vecs[16] = '{32'h02105093, 3'd2, 5'd1, 5'd0, 5'd0, 3'd5, 7'h01, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000001, 64'h1};
    vecs[17] = '{32'h000080E7, 3'd1, 5'd1, 5'd1, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 64'h0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; in_pc = 32'h0; in_pc64 = 64'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(o_vld), 64'd0);
    chk("rst_in_ready", 64'(o_rdy), 64'd0);
    chk("rst_dec_count", 64'(o_cnt), 64'd0);
    chk("rst_imm", 64'(o_imm), 64'd0);
    chk("rst_fmt", 64'(o_fmt), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(o_rdy), 64'd1);

    // Table of single instructions, each checked one cycle after its input transfer
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = 32'h1000 + 32'(i * 4);
      in_pc64  = {32'hCAFE0000, in_pc};
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), 64'(o_vld), 64'd1);
      chk($sformatf("v%0d_opcode", i), 64'(o_op), 64'(vecs[i].instr[6:0]));
      chk($sformatf("v%0d_fmt", i), 64'(o_fmt), 64'(vecs[i].fmt));
      chk($sformatf("v%0d_rd", i), 64'(o_rd), 64'(vecs[i].rd));
      chk($sformatf("v%0d_rs1", i), 64'(o_rs1), 64'(vecs[i].rs1));
      chk($sformatf("v%0d_rs2", i), 64'(o_rs2), 64'(vecs[i].rs2));
      chk($sformatf("v%0d_funct3", i), 64'(o_f3), 64'(vecs[i].f3));
      chk($sformatf("v%0d_funct7", i), 64'(o_f7), 64'(vecs[i].f7));
      chk($sformatf("v%0d_imm", i), 64'(o_imm), 64'(vecs[i].imm));
      chk($sformatf("v%0d_pc", i), 64'(o_pc), 64'(32'h1000 + 32'(i * 4)));
      chk($sformatf("v%0d_illegal", i), 64'(o_ill), 64'(vecs[i].ill));
      chk($sformatf("v%0d_lock_req", i), 64'(o_lreq), 64'(vecs[i].lreq));
      chk($sformatf("v%0d_lock_rel", i), 64'(o_lrel), 64'(vecs[i].lrel));
      chk($sformatf("v%0d_nl_illegal", i), 64'(n_ill), 64'(vecs[i].ill_nl));
      chk($sformatf("v%0d_nl_imm", i), 64'(n_imm), 64'(vecs[i].imm_z));
      chk($sformatf("v%0d_nl_lock_req", i), 64'(n_lreq), 64'(vecs[i].lreq & ~vecs[i].ill_nl));
      chk($sformatf("v%0d_x64_imm", i), w_imm, vecs[i].imm64);
      chk($sformatf("v%0d_x64_pc", i), w_pc, {32'hCAFE0000, 32'h1000 + 32'(i * 4)});
      exp_cnt++;
    end

    // Backpressure: three back-to-back inputs against a stalled consumer
    @(negedge clk);
    chk("table_dec_count", 64'(o_cnt), 64'(exp_cnt));
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093;
    @(negedge clk);
    chk("bp_ready_after_1", 64'(o_rdy), 64'd1);
    in_instr = 32'h00200113;
    @(negedge clk);
    chk("bp_ready_after_2", 64'(o_rdy), 64'd0);
    in_instr = 32'h00300193;
    @(negedge clk);
    chk("bp_ready_held", 64'(o_rdy), 64'd0);
    chk("bp_first_rd", 64'(o_rd), 64'd1);
    chk("bp_first_imm", 64'(o_imm), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_second_rd", 64'(o_rd), 64'd2);
    chk("bp_ready_reopen", 64'(o_rdy), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_third_rd", 64'(o_rd), 64'd3);
    chk("bp_third_valid", 64'(o_vld), 64'd1);
    @(negedge clk);
    exp_cnt += 3;
    chk("bp_drained", 64'(o_vld), 64'd0);
    chk("bp_dec_count", 64'(o_cnt), 64'(exp_cnt));

    // Flush in FULL with a pending input, then flush in ONE with an accepted-looking input
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00000213;
    @(negedge clk);
    in_instr = 32'h00000293;
    @(negedge clk);
    chk("fl_full", 64'(o_rdy), 64'd0);
    flush = 1'b1; in_instr = 32'h00000313;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_full_valid", 64'(o_vld), 64'd0);
    chk("fl_full_ready", 64'(o_rdy), 64'd1);
    in_valid = 1'b1; in_instr = 32'h00000393;
    @(negedge clk);
    chk("fl_one_rd", 64'(o_rd), 64'd7);
    flush = 1'b1; in_instr = 32'h00000413;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_one_valid", 64'(o_vld), 64'd0);
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00000493;
    @(negedge clk);
    in_valid = 1'b0;
    chk("fl_after_valid", 64'(o_vld), 64'd1);
    chk("fl_after_rd", 64'(o_rd), 64'd9);
    @(negedge clk);
    exp_cnt += 1;
    chk("fl_after_empty", 64'(o_vld), 64'd0);
    chk("fl_dec_count", 64'(o_cnt), 64'(exp_cnt));

    // Counter wrap: stream until the count reaches 0xFFFF, then one more transfer
    in_valid = 1'b1; in_instr = 32'h00000013;
    repeat (65535 - exp_cnt) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("wrap_max", 64'(o_cnt), 64'hFFFF);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("wrap_zero", 64'(o_cnt), 64'd0);

    // Reset mid-stream with both registers occupied
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h2000;
    @(negedge clk);
    in_instr = 32'h00200113;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("mrst_valid", 64'(o_vld), 64'd0);
    chk("mrst_ready", 64'(o_rdy), 64'd0);
    chk("mrst_count", 64'(o_cnt), 64'd0);
    chk("mrst_rd", 64'(o_rd), 64'd0);
    chk("mrst_imm", 64'(o_imm), 64'd0);
    chk("mrst_pc", 64'(o_pc), 64'd0);
    rst = 1'b0; flush = 1'b0;
    #1;
    chk("mrst_release_ready", 64'(o_rdy), 64'd1);
    @(negedge clk);
    chk("mrst_discarded", 64'(o_vld), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_decode_pipe.md
INSTR_DECODE_PIPE -- requirements
Module: instr_decode_pipe

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the width of the program counter and the immediate datapath; legal values are 32 and 64.
REQ-002 Parameter LOCK_EN, default 1, SHALL enable decoding of the custom lock opcodes (0x40 afl, 0x20 nml) and the custom load/store opcodes (0x7E, 0x7F); when it is 0 these opcodes SHALL decode as illegal.
REQ-003 Parameter SEXT, default 1, SHALL select immediates sign-extended to XLEN when 1 and zero-extended when 0.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port flush, input, 1 bit: discards all held entries.
REQ-007 Ports in_valid (input, 1), in_ready (output, 1), in_instr (input, 32) and in_pc (input, XLEN) SHALL form the upstream handshake.
REQ-008 Ports out_valid (output, 1) and out_ready (input, 1) SHALL form the downstream handshake.
REQ-009 Output out_opcode SHALL be 7 bits.
REQ-010 Output out_funct3 SHALL be 3 bits.
REQ-011 Output out_funct7 SHALL be 7 bits.
REQ-012 Outputs out_rs1, out_rs2 and out_rd SHALL be 5 bits each.
REQ-013 Output out_imm SHALL be XLEN bits.
REQ-014 Output out_pc SHALL be XLEN bits.
REQ-015 Output out_fmt SHALL be 3 bits, encoded 0=R, 1=I, 2=SH (shift-immediate), 3=S, 4=B, 5=U, 6=J, 7=LOCK.
REQ-016 Outputs out_illegal, out_lock_req and out_lock_rel SHALL be 1 bit each.
REQ-017 Output dec_count SHALL be 16 bits and SHALL count accepted output transfers.

Function
REQ-018 A transfer SHALL occur on a cycle where valid and ready are both 1; latency from input transfer to out_valid SHALL be exactly 1 cycle.
REQ-019 Storage SHALL be one output register plus one skid register, with states EMPTY (no entry), ONE (output register valid) and FULL (both valid).
REQ-020 in_ready SHALL be 1 exactly when the state is not FULL; in_ready SHALL be registered and SHALL NOT depend combinationally on out_ready.
REQ-021 EMPTY SHALL move to ONE on an input transfer.
REQ-022 ONE SHALL stay in ONE on simultaneous input and output transfers, go to EMPTY on an output transfer alone, and go to FULL on an input transfer alone.
REQ-023 In FULL, an output transfer SHALL move the skid entry into the output register and the state SHALL go to ONE.
REQ-024 Entries SHALL leave in arrival order; no entry SHALL be dropped or duplicated.
REQ-025 Decode SHALL be performed before the register stage, and only decoded fields SHALL be stored.
REQ-026 R format (opcode 0x33) SHALL fill funct7, rs2, rs1 and rd.
REQ-027 SH format (opcode 0x13 with funct3 001 or 101) SHALL set imm to instr[24:20] zero-extended and funct7 to instr[31:25]; funct7 values other than 0x00, and other than 0x20 with funct3=101, SHALL set out_illegal.
REQ-028 I format (opcode 0x13, 0x67, 0x03, 0x7E) SHALL set imm from instr[31:20].
REQ-029 S format (opcode 0x23, 0x7F) SHALL set imm from {instr[31:25], instr[11:7]}.
REQ-030 B format (opcode 0x63) SHALL set imm from {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
REQ-031 U format (opcode 0x37, 0x17) SHALL set imm to {instr[31:12], 12'b0}.
REQ-032 J format (opcode 0x6F) SHALL set imm from {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-033 LOCK format SHALL set imm from instr[31:12] zero-extended, set out_lock_req for opcode 0x40, and set out_lock_rel for opcode 0x20.
REQ-034 Every field not used by the decoded format SHALL be 0.
REQ-035 Any unlisted opcode SHALL set out_illegal=1 with all other fields 0 except out_opcode and out_pc.
REQ-036 The U-format and J-format immediate sign extension SHALL follow SEXT when XLEN=64.
REQ-037 flush SHALL set the state to EMPTY on the next edge and SHALL override any simultaneous input transfer.
REQ-038 dec_count SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-039 While rst=1, the state SHALL be EMPTY, out_valid=0, in_ready=0, and all output fields and dec_count SHALL be 0.
REQ-040 On the first cycle after rst is released, in_ready SHALL be 1.
REQ-041 rst asserted mid-operation SHALL discard all entries.
REQ-042 rst SHALL have priority over flush.

Verification
REQ-043 Scenario, I format: instr 0xFFF00093, SEXT=1, XLEN=32, out_ready=1 -> after 1 cycle out_fmt=1, rd=1, rs1=0, imm=0xFFFFFFFF.
REQ-044 Scenario, backpressure: 3 back-to-back inputs with out_ready=0 -> in_ready=0 after the 2nd input; outputs emerge in order once out_ready=1; dec_count=3.
REQ-045 Scenario, lock and illegal: instr 0x00001040 -> out_lock_req=1, imm=0x1, rd=0; the same instr with LOCK_EN=0 -> out_illegal=1.
REQ-046 Scenario, shift check: instr 0x40105093 (SRAI) -> illegal=0; instr 0x40101093 (SLLI with funct7=0x20) -> illegal=1.
REQ-047 Scenario, flush and reset: flush asserted while FULL together with in_valid=1 -> next cycle out_valid=0 and in_ready=1; rst asserted mid-stream -> all outputs 0 and dec_count=0.
